// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU, with a registered response slot.
// Define ALU_ARB_FIXED_PRIO_EN to make requester 0 always win contention instead of round-robin.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] resp_result_q, resp_result_d;
  logic             resp_zero_q, resp_zero_d;
  logic             resp_id_q, resp_id_d;
  logic             grant_valid;
  logic             grant_idx;

  // The slot reopens in HOLD as soon as the consumer takes the current response.
  assign grant_valid = !rst && (state_q == IDLE || resp_ready) && (req0_valid || req1_valid);

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign grant_idx = ~req0_valid;
`else
  logic last_grant_q, last_grant_d;

  assign grant_idx    = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
  assign last_grant_d = grant_valid ? grant_idx : last_grant_q;

  // Reset value 1 lets requester 0 win the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= 1'b1;
    else     last_grant_q <= last_grant_d;
  end
`endif

  always_comb begin
    state_d       = state_q;
    resp_result_d = resp_result_q;
    resp_zero_d   = resp_zero_q;
    resp_id_d     = resp_id_q;
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    alu_a         = '0;
    alu_b         = '0;
    alu_ctrl      = 3'b000;
    if (grant_valid) begin
      if (grant_idx) begin
        req1_ready = 1'b1;
        alu_a      = req1_a;
        alu_b      = req1_b;
        alu_ctrl   = req1_ctrl;
      end else begin
        req0_ready = 1'b1;
        alu_a      = req0_a;
        alu_b      = req0_b;
        alu_ctrl   = req0_ctrl;
      end
      state_d       = HOLD;
      resp_result_d = alu_result;
      resp_zero_d   = alu_zero;
      resp_id_d     = grant_idx;
    end else if (state_q == HOLD && resp_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      resp_result_q <= '0;
      resp_zero_q   <= 1'b0;
      resp_id_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      resp_result_q <= resp_result_d;
      resp_zero_q   <= resp_zero_d;
      resp_id_q     <= resp_id_d;
    end
  end

  assign resp_valid  = (state_q == HOLD);
  assign resp_result = resp_result_q;
  assign resp_zero   = resp_zero_q;
  assign resp_id     = resp_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a reference ALU, a transaction-level model checked every cycle,
// and directed vectors with hand-computed expectations.
module tb_alu_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_ctrl, req1_ctrl;
  logic [W-1:0] alu_a, alu_b;
  logic [2:0]   alu_ctrl;
  logic [W-1:0] alu_result;
  logic         alu_zero;
  logic         resp_valid, resp_ready, resp_id, resp_zero;
  logic [W-1:0] resp_result;

  int total = 0;
  int bad   = 0;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_zero(resp_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c);
    case (c)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return ($signed(a) < $signed(b)) ? 1 : 0;
      3'b110:  return a >> b[4:0];
      default: return '0;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_fn(alu_a, alu_b, alu_ctrl);
    alu_zero   = (alu_result == '0);
  end

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Response-slot model: one pending response, consumed when resp_ready is high.
  logic         m_pending = 1'b0;
  logic [W-1:0] m_result  = '0;
  logic         m_zero    = 1'b0;
  logic         m_id      = 1'b0;
  logic         m_last    = 1'b1;

  always begin
    logic         g_any, g_who;
    logic [W-1:0] ea, eb;
    logic [2:0]   ec;
    @(negedge clk);
    if (rst) begin
      m_pending = 1'b0; m_result = '0; m_zero = 1'b0; m_id = 1'b0; m_last = 1'b1;
    end
    g_any = !rst && (!m_pending || resp_ready) && (req0_valid || req1_valid);
`ifdef ALU_ARB_FIXED_PRIO_EN
    g_who = req0_valid ? 1'b0 : 1'b1;
`else
    if (req0_valid && req1_valid) g_who = (m_last == 1'b0) ? 1'b1 : 1'b0;
    else                          g_who = req0_valid ? 1'b0 : 1'b1;
`endif
    ea = '0; eb = '0; ec = 3'b000;
    if (g_any) begin
      ea = g_who ? req1_a : req0_a;
      eb = g_who ? req1_b : req0_b;
      ec = g_who ? req1_ctrl : req0_ctrl;
    end
    checkOutput("m_req0_ready",  {31'b0, req0_ready}, {31'b0, g_any && !g_who});
    checkOutput("m_req1_ready",  {31'b0, req1_ready}, {31'b0, g_any && g_who});
    checkOutput("m_alu_a",       alu_a, ea);
    checkOutput("m_alu_b",       alu_b, eb);
    checkOutput("m_alu_ctrl",    {29'b0, alu_ctrl}, {29'b0, ec});
    checkOutput("m_resp_valid",  {31'b0, resp_valid}, {31'b0, m_pending});
    checkOutput("m_resp_result", resp_result, m_result);
    checkOutput("m_resp_zero",   {31'b0, resp_zero}, {31'b0, m_zero});
    checkOutput("m_resp_id",     {31'b0, resp_id}, {31'b0, m_id});
    if (g_any) begin
      m_pending = 1'b1;
      m_result  = alu_fn(ea, eb, ec);
      m_zero    = (m_result == '0);
      m_id      = g_who;
      m_last    = g_who;
    end else if (m_pending && resp_ready) begin
      m_pending = 1'b0;
    end
  end

  task automatic applyStimulus(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [2:0] c0,
                               input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [2:0] c1,
                               input logic rr);
    @(posedge clk);
    #1;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_ctrl = c0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_ctrl = c1;
    resp_ready = rr;
  endtask

  initial begin
    logic exp0;
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = 1; req0_b = 1; req0_ctrl = 3'b000;
    req1_valid = 1'b0; req1_a = 0; req1_b = 0; req1_ctrl = 3'b000;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_req0_ready", {31'b0, req0_ready}, 0);
    checkOutput("rst_resp_valid", {31'b0, resp_valid}, 0);
    checkOutput("rst_resp_result", resp_result, 0);

    // single request: ADD 5+7
    applyStimulus(1, 5, 7, 3'b000, 0, 0, 0, 3'b000, 1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("single_req0_ready", {31'b0, req0_ready}, 1);
    checkOutput("single_alu_ctrl", {29'b0, alu_ctrl}, 0);
    checkOutput("single_alu_a", alu_a, 5);
    applyStimulus(0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 1);
    @(negedge clk);
    checkOutput("single_resp_valid", {31'b0, resp_valid}, 1);
    checkOutput("single_resp_result", resp_result, 12);
    checkOutput("single_resp_id", {31'b0, resp_id}, 0);
    checkOutput("single_resp_zero", {31'b0, resp_zero}, 0);

    // backpressure: req1 SUB 9-9 then consumer stalls
    applyStimulus(0, 0, 0, 3'b000, 1, 9, 9, 3'b001, 0);
    @(negedge clk);
    checkOutput("bp_req1_ready", {31'b0, req1_ready}, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'hC, 32'hA, 3'b010, 1, 3, 4, 3'b011, 0);
      @(negedge clk);
      checkOutput("bp_resp_result", resp_result, 0);
      checkOutput("bp_resp_zero", {31'b0, resp_zero}, 1);
      checkOutput("bp_resp_id", {31'b0, resp_id}, 1);
      checkOutput("bp_req0_ready", {31'b0, req0_ready}, 0);
      checkOutput("bp_req1_ready", {31'b0, req1_ready}, 0);
    end

    // contention with consumer ready
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 32'hC, 32'hA, 3'b010, 1, 3, 4, 3'b011, 1);
      @(negedge clk);
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp0 = 1'b1;
`else
      exp0 = (i % 2 == 0);
`endif
      checkOutput("cont_req0_ready", {31'b0, req0_ready}, {31'b0, exp0});
      checkOutput("cont_req1_ready", {31'b0, req1_ready}, {31'b0, !exp0});
    end

    // back-to-back: XOR while HOLD with resp_ready
    applyStimulus(1, 32'hF0, 32'h0F, 3'b100, 0, 0, 0, 3'b000, 1);
    @(negedge clk);
    checkOutput("b2b_req0_ready", {31'b0, req0_ready}, 1);
    checkOutput("b2b_alu_ctrl", {29'b0, alu_ctrl}, 4);
    applyStimulus(1, 32'hFFFF_FFFF, 1, 3'b101, 0, 0, 0, 3'b000, 1);
    @(negedge clk);
    checkOutput("b2b_resp_valid", {31'b0, resp_valid}, 1);
    checkOutput("b2b_resp_result", resp_result, 32'hFF);
    checkOutput("b2b_req0_ready", {31'b0, req0_ready}, 1);

    // stalled HOLD, requester withdraws without grant; then SRL and drain
    applyStimulus(0, 0, 0, 3'b000, 1, 32'h8000_0000, 31, 3'b110, 0);
    applyStimulus(0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 0);
    @(negedge clk);
    checkOutput("slt_resp_result", resp_result, 1);
    applyStimulus(0, 0, 0, 3'b000, 1, 32'h8000_0000, 28, 3'b110, 1);
    applyStimulus(0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 1);
    @(negedge clk);
    checkOutput("srl_resp_result", resp_result, 8);
    applyStimulus(0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 1);

    // reset during HOLD
    applyStimulus(1, 32'hFFFF_FFFF, 1, 3'b000, 0, 0, 0, 3'b000, 1);
    applyStimulus(0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 0);
    @(negedge clk);
    checkOutput("wrap_resp_zero", {31'b0, resp_zero}, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_hold_resp_valid", {31'b0, resp_valid}, 0);
    checkOutput("rst_hold_resp_zero", {31'b0, resp_zero}, 0);
    @(negedge clk);
    applyStimulus(1, 2, 3, 3'b000, 1, 4, 5, 3'b000, 1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_req0_ready", {31'b0, req0_ready}, 1);
    checkOutput("post_rst_req1_ready", {31'b0, req1_ready}, 0);
    applyStimulus(1, 2, 3, 3'b000, 1, 4, 5, 3'b000, 1);
    applyStimulus(0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 1);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req0_valid / req1_valid  input  1  requester n has an operation pending.
REQ-005 req0_ready / req1_ready  output  1  requester n's operation is accepted this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands of requester n.
REQ-007 req0_ctrl / req1_ctrl  input  3  alu_control code of requester n (000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SRL).
REQ-008 alu_a, alu_b  output  WIDTH  operands driven to the shared ALU.
REQ-009 alu_ctrl  output  3  control code driven to the shared ALU.
REQ-010 alu_result  input  WIDTH  combinational result from the shared ALU.
REQ-011 alu_zero  input  1  zero flag from the shared ALU.
REQ-012 resp_valid  output  1  registered result available.
REQ-013 resp_ready  input  1  consumer accepts the response.
REQ-014 resp_id  output  1  index of the requester that owns the response.
REQ-015 resp_result  output  WIDTH  registered ALU result.
REQ-016 resp_zero  output  1  registered zero flag.

Function
REQ-017 Two-state FSM:
- IDLE: resp_valid=0.
- HOLD: resp_valid=1.
REQ-018 Issue slot:
- Open in IDLE.
- Open in HOLD only when resp_ready=1.
REQ-019 Grant:
- Open slot with at least one reqN_valid: exactly one requester is granted and its reqN_ready=1 combinationally.
- All other ready outputs are 0.
REQ-020 Round-robin:
- Both valid: grant the requester other than last_grant.
- One valid: grant it.
REQ-021 last_grant is updated to the granted index on each grant.
REQ-022 ALU drive:
- While a grant is active, alu_a/alu_b/alu_ctrl equal the granted requester's operands and ctrl in the same cycle.
- Otherwise all are 0 (ctrl 000).
REQ-023 Latency:
- Capture: on the edge ending a grant cycle, alu_result, alu_zero and the granted index load into resp_result, resp_zero and resp_id, and the FSM enters HOLD.
- The response is visible exactly 1 cycle after acceptance.
REQ-024 HOLD with resp_ready=0: all resp_* outputs are held stable and both ready outputs are 0.
REQ-025 HOLD with resp_ready=1:
- Request valid: the new grant and capture happen back-to-back and the FSM stays in HOLD, giving 1 operation/cycle throughput.
- No request valid: the FSM returns to IDLE.
REQ-026 resp_result, resp_zero and resp_id change only on a capture edge.
REQ-027 A reqN_valid deassertion without a grant is legal; no state changes.

Reset
REQ-028 While rst=1:
- FSM=IDLE.
- resp_valid=0, resp_result=0, resp_zero=0, resp_id=0.
- last_grant=1, so requester 0 wins the first contention.
REQ-029 Reset mid-HOLD discards the pending response immediately (asynchronously).
REQ-030 No grant is issued while rst=1.

Configuration
REQ-031 Macro ALU_ARB_FIXED_PRIO_EN:
- Defined: requester 0 always wins contention and last_grant is not used.
- Undefined: the round-robin rule of REQ-020 applies.
- All other behaviour is identical in both builds.

Verification
REQ-032 Single request: req0 ADD 5+7 in IDLE -> req0_ready=1, alu_ctrl=000; next cycle resp_valid=1, resp_result=12, resp_id=0, resp_zero=0.
REQ-033 Contention: both valid every cycle, resp_ready=1 -> grants 0,1,0,1 on consecutive cycles; with ALU_ARB_FIXED_PRIO_EN -> 0,0,0,0.
REQ-034 Backpressure: req1 SUB 9-9 accepted, resp_ready=0 for 3 cycles -> resp_result=0, resp_zero=1, resp_id=1 held stable; both ready outputs 0 throughout.
REQ-035 Back-to-back: HOLD with resp_ready=1 and req0 XOR 0xF0^0x0F valid -> same-cycle grant; next cycle resp_result=0xFF with no IDLE bubble.
REQ-036 Reset: rst asserted during HOLD -> resp_valid=0 immediately; after release with both requests valid, requester 0 is granted first.
